// File: rtl/spi_pkg.sv
// Shared types for the SPI master controller: frame codes,
// host op encoding, controller states and a frame-code helper.
package spi_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } frame_code_e;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_CMD,
    S_SHIFT,
    S_RD_WAIT,
    S_RD_SHIFT,
    S_GAP,
    S_DONE
  } ctrl_state_e;

  // Frame 1 carries the address, frame 2 the data; code[1] is the op.
  function automatic frame_code_e frame_code(op_e op, logic ph);
    return frame_code_e'({op == OP_RD, ph});
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Frame shifter: loads {code, word}, shifts it out MSB first while
// shifting MISO in at the LSB, and runs a down-counter with done flag.
// Ports: i_load/i_vec load the vector, i_cnt_ld/i_cnt load the counter,
// i_shift advances both, o_msb is the next MOSI bit, o_rx_nxt is the
// received word including the MISO bit sampled on this edge.
module spi_frame_shifter #(
  parameter int PW = 10,
  parameter int AW = 8,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [PW-1:0] i_vec,
  input  logic          i_cnt_ld,
  input  logic [CW-1:0] i_cnt,
  input  logic          i_shift,
  input  logic          i_miso,
  output logic          o_msb,
  output logic [AW-1:0] o_rx_nxt,
  output logic          o_done
);

  logic [PW-1:0] r_sreg;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_load)
        r_sreg <= i_vec;
      else if (i_shift)
        r_sreg <= {r_sreg[PW-2:0], i_miso};
      if (i_cnt_ld)
        r_cnt <= i_cnt;
      else if (i_shift)
        r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_msb    = r_sreg[PW-1];
  assign o_rx_nxt = {r_sreg[AW-2:0], i_miso};
  assign o_done   = (r_cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: turns host write/read commands into two SPI
// frames (addr then data) and returns a one-cycle response strobe.
// Host side: cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_wdata in,
// rsp_valid/rsp_data/busy out. Pins: SS_n, MOSI out, MISO in.
module spi_master_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int RD_WAIT   = 2,
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_op,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [ADDR_SIZE-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_data,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  import spi_pkg::*;

  localparam int PW = ADDR_SIZE + 2;
  localparam int CW = $clog2(PW + RD_WAIT + ADDR_SIZE + 1);
  localparam logic [CW-1:0] C_PW = CW'(PW);
  localparam logic [CW-1:0] C_RW = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] C_AW = CW'(ADDR_SIZE - 1);

  ctrl_state_e          r_state;
  ctrl_state_e          w_nxt;
  op_e                  r_op;
  logic                 r_ph;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [ADDR_SIZE-1:0] r_wdata;
  logic                 r_ss_n;
  logic                 r_mosi;
  logic                 r_rsp_valid;
  logic [ADDR_SIZE-1:0] r_rsp_data;

  logic                 w_load;
  logic                 w_cnt_ld;
  logic [CW-1:0]        w_cnt;
  logic                 w_shift;
  logic                 w_done;
  logic                 w_msb;
  logic [ADDR_SIZE-1:0] w_rx_nxt;
  logic [ADDR_SIZE-1:0] w_word;
  logic [PW-1:0]        w_vec;
  logic                 w_accept;
  logic                 w_sel_nxt;
  logic                 w_mosi_nxt;

  assign w_accept = (r_state == S_IDLE) && cmd_valid;
  assign w_word   = !r_ph ? r_addr :
                    (r_op == OP_RD) ? '0 : r_wdata;
  assign w_vec    = {frame_code(r_op, r_ph), w_word};

  spi_frame_shifter #(
    .PW(PW),
    .AW(ADDR_SIZE),
    .CW(CW)
  ) u_shf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_vec    (w_vec),
    .i_cnt_ld (w_cnt_ld),
    .i_cnt    (w_cnt),
    .i_shift  (w_shift),
    .i_miso   (MISO),
    .o_msb    (w_msb),
    .o_rx_nxt (w_rx_nxt),
    .o_done   (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_nxt;
  end

  // Counter is loaded to PW in SEL so it reads 0 on the last SHIFT cycle.
  always_comb begin
    w_nxt    = r_state;
    w_load   = 1'b0;
    w_cnt_ld = 1'b0;
    w_cnt    = C_PW;
    w_shift  = 1'b0;
    unique case (r_state)
      S_IDLE: if (cmd_valid) w_nxt = S_SEL;
      S_SEL: begin
        w_load   = 1'b1;
        w_cnt_ld = 1'b1;
        w_nxt    = S_CMD;
      end
      S_CMD: begin
        w_shift = 1'b1;
        w_nxt   = S_SHIFT;
      end
      S_SHIFT: begin
        if (!w_done)
          w_shift = 1'b1;
        else if (!r_ph)
          w_nxt = S_GAP;
        else if (r_op == OP_WR)
          w_nxt = S_DONE;
        else if (RD_WAIT == 0) begin
          w_nxt    = S_RD_SHIFT;
          w_cnt_ld = 1'b1;
          w_cnt    = C_AW;
        end else begin
          w_nxt    = S_RD_WAIT;
          w_cnt_ld = 1'b1;
          w_cnt    = C_RW;
        end
      end
      S_RD_WAIT: begin
        if (w_done) begin
          w_nxt    = S_RD_SHIFT;
          w_cnt_ld = 1'b1;
          w_cnt    = C_AW;
        end else
          w_shift = 1'b1;
      end
      S_RD_SHIFT: begin
        w_shift = 1'b1;
        if (w_done) w_nxt = S_DONE;
      end
      S_GAP:  w_nxt = S_SEL;
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Pins are registered from the next state so they line up with it.
  assign w_sel_nxt = w_nxt inside
    {S_SEL, S_CMD, S_SHIFT, S_RD_WAIT, S_RD_SHIFT};

  always_comb begin
    w_mosi_nxt = 1'b0;
    unique case (1'b1)
      (w_nxt == S_CMD):   w_mosi_nxt = (r_op == OP_RD);
      (w_nxt == S_SHIFT): w_mosi_nxt = w_msb;
      default:            w_mosi_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= OP_WR;
      r_ph        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= op_e'(cmd_op);
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        r_ph    <= 1'b0;
      end else if (r_state == S_GAP)
        r_ph <= 1'b1;
      r_ss_n      <= !w_sel_nxt;
      r_mosi      <= w_mosi_nxt;
      r_rsp_valid <= (w_nxt == S_DONE);
      r_rsp_data  <= ((w_nxt == S_DONE) && (r_op == OP_RD)) ?
                     w_rx_nxt : '0;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = !((r_state == S_IDLE) || (r_state == S_DONE));
  assign SS_n      = r_ss_n;
  assign MOSI      = r_mosi;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule
